// File: rtl/proc_pkg.sv
// Shared processor constants and the fetch-stage state encoding.
package proc_pkg;

    localparam int N_DFLT        = 8;
    localparam int RESET_PC_DFLT = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Entries committed or pending in the fetch path, used for the issue room test.
    function automatic int fetch_occupancy(input int count, input logic inflight, input logic pop);
        return count + int'(inflight) - int'(pop);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Generic DEPTH-entry synchronous FIFO with flush; head word visible combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full without a same-cycle pop; pop on empty is ignored.
module fetch_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_vld,
    output logic [WIDTH-1:0]           head_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;

    assign pop_ok   = pop && (count != '0);
    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && (count == CW'(DEPTH)) && !pop_ok));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues one PC per cycle to memory port 1, pairs the returned word with its PC.
// Latency: address in cycle t, word captured end of t+1, inst_valid in t+2.
// Backpressure: issue only while buffer + in-flight leaves room; decode drains via valid/ready.
module fetch_stage
    import proc_pkg::*;
#(
    parameter int           n        = N_DFLT,
    parameter int           DEPTH    = 2,
    parameter logic [n-1:0] RESET_PC = n'(RESET_PC_DFLT)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [n-1:0] mem_addr,
    input  logic [n-1:0] mem_data,
    output logic [n-1:0] inst,
    output logic [n-1:0] inst_pc,
    output logic         inst_valid,
    input  logic         inst_ready,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    input  logic         halt,
    output logic         halted
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [n-1:0] word;
        logic [n-1:0] pc;
    } fetch_ent_t;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [n-1:0]  pc;
    logic [n-1:0]  inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic          buf_vld;
    logic          pop;
    logic          push;
    logic          fetch_en;
    logic          issue;
    fetch_ent_t    push_ent;
    fetch_ent_t    head_ent;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirect never overrides halt: with halt high the state lands in HALT either way.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (halt)  state_nxt = HALT;
            HALT:    if (!halt) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        fetch_en = 1'b0;
        halted   = 1'b0;
        case (state)
            RUN:     fetch_en = !halt;
            HALT:    halted   = !inflight;
            default: fetch_en = 1'b0;
        endcase
    end

    assign pop   = buf_vld && inst_ready;
    assign issue = fetch_en && !redirect
                   && (fetch_occupancy(int'(count), inflight, pop) < DEPTH);

    // The word returning in a redirect cycle belongs to the old stream and is dropped.
    assign push     = inflight && !redirect;
    assign push_ent = '{word: mem_data, pc: inflight_pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + n'(1);
                inflight_pc <= pc;
            end
        end
    end

    fetch_buf #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (redirect),
        .count    (count),
        .head_vld (buf_vld),
        .head_dat (head_ent)
    );

    assign mem_addr   = pc;
    assign inst       = head_ent.word;
    assign inst_pc    = head_ent.pc;
    assign inst_valid = buf_vld;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected {word,pc}, a negedge monitor checks deliveries.
module tb_fetch_stage;

    localparam int N     = 8;
    localparam int DEPTH = 2;
    localparam logic [7:0] WMASK = 8'h3C;

    typedef struct packed {
        logic [7:0] word;
        logic [7:0] pc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] inst;
    logic [7:0] inst_pc;
    logic       inst_valid;
    logic       inst_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt;
    logic       halted;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_stage #(.n(N), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word k holds k ^ WMASK so word and PC differ.
    always @(posedge clk) mem_data <= mem_addr ^ WMASK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_pc(input logic [7:0] p);
        exp_t e;
        e.word = p ^ WMASK;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_addr(input logic [7:0] a, input string name);
        for (int i = 0; i < 60 && mem_addr !== a; i++) cyc(1);
        chk(name, mem_addr, a);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1);
        cyc(2);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_addr"},   mem_addr,   8'h00);
        chk({tag, "_inst_valid"}, inst_valid, 1'b0);
        chk({tag, "_inst"},       inst,       8'h00);
        chk({tag, "_inst_pc"},    inst_pc,    8'h00);
        chk({tag, "_halted"},     halted,     1'b0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %0h word %0h, expected none", inst_pc, inst);
            end else begin
                e = exp_q.pop_front();
                chk("inst_stream", {inst, inst_pc}, e);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        inst_ready  = 1'b0;
        #3;
        chk_reset("por");

        // Streaming from reset, then halt with pc 9 in flight.
        cyc(1);
        rst        = 1'b0;
        inst_ready = 1'b1;
        for (int p = 0; p < 10; p++) expect_pc(8'(p));
        chk("c0_addr", mem_addr, 8'h00);
        chk("c0_valid", inst_valid, 1'b0);
        cyc(1);
        chk("c1_addr", mem_addr, 8'h01);
        chk("c1_valid", inst_valid, 1'b0);
        cyc(1);
        chk("c2_valid", inst_valid, 1'b1);
        chk("c2_pc", inst_pc, 8'h00);
        wait_addr(8'h0A, "reach_pc10");
        halt = 1'b1;
        chk("halted_not_yet", halted, 1'b0);
        cyc(1);
        chk("halted_set", halted, 1'b1);
        cyc(2);
        chk("halt_addr_held", mem_addr, 8'h0A);
        drain("drain_halt");

        // Resume at 10, redirect to 0x40 with pc 15 in flight and 14 buffered.
        for (int p = 10; p < 14; p++) expect_pc(8'(p));
        halt = 1'b0;
        cyc(1);
        chk("halted_clear", halted, 1'b0);
        wait_addr(8'h10, "reach_pc16");
        chk("pre_redirect_q", exp_q.size(), 0);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        inst_ready  = 1'b0;
        for (int p = 8'h40; p < 8'h45; p++) expect_pc(8'(p));
        cyc(1);
        redirect   = 1'b0;
        inst_ready = 1'b1;
        chk("redir_t1_valid", inst_valid, 1'b0);
        chk("redir_t1_addr", mem_addr, 8'h40);
        cyc(1);
        chk("redir_t2_valid", inst_valid, 1'b0);
        cyc(1);
        chk("redir_t3_valid", inst_valid, 1'b1);
        chk("redir_t3_pc", inst_pc, 8'h40);
        wait_addr(8'h45, "reach_pc45");
        halt = 1'b1;
        cyc(3);
        drain("drain_redirect");
        chk("halted_after_redirect", halted, 1'b1);

        // Redirect while halting loads pc only; then run across the 0xFF->0x00 wrap.
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        cyc(1);
        redirect = 1'b0;
        chk("redir_halt_addr", mem_addr, 8'hFE);
        chk("redir_halt_halted", halted, 1'b1);
        expect_pc(8'hFE);
        expect_pc(8'hFF);
        expect_pc(8'h00);
        expect_pc(8'h01);
        halt = 1'b0;
        wait_addr(8'h02, "reach_wrap");
        halt = 1'b1;
        cyc(3);
        drain("drain_wrap");

        // Fill the buffer with decode stalled, then reset between clock edges.
        inst_ready = 1'b0;
        halt       = 1'b0;
        cyc(5);
        chk("fill_addr", mem_addr, 8'h04);
        chk("fill_valid", inst_valid, 1'b1);
        chk("fill_head_pc", inst_pc, 8'h02);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        cyc(2);

        // Stall decode for five cycles from reset release, then drain.
        rst = 1'b0;
        cyc(1);
        chk("bp_c1_addr", mem_addr, 8'h01);
        cyc(2);
        chk("bp_c3_addr", mem_addr, 8'h02);
        chk("bp_c3_valid", inst_valid, 1'b1);
        chk("bp_c3_pc", inst_pc, 8'h00);
        cyc(1);
        chk("bp_c4_addr", mem_addr, 8'h02);
        for (int p = 0; p < 4; p++) expect_pc(8'(p));
        cyc(1);
        inst_ready = 1'b1;
        wait_addr(8'h04, "reach_pc4");
        halt = 1'b1;
        cyc(3);
        drain("drain_backpressure");
        chk("halted_final", halted, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
